// File: rtl/hack_cpu_ctrl_if.sv
// Bus bundle between the Hack CPU controller and its fetch port, data memory and ALU.
// master = the controller, slave = the surrounding system.
interface hack_cpu_ctrl_if #(
    parameter int PC_W = 15
);
    logic [15:0]     inst;
    logic            inst_vld;
    logic [PC_W-1:0] pc;
    logic [15:0]     in_m;
    logic            in_m_vld;
    logic [15:0]     out_m;
    logic            write_m;
    logic [PC_W-1:0] addr_m;
    logic [15:0]     alu_x;
    logic [15:0]     alu_y;
    logic            zx;
    logic            nx;
    logic            zy;
    logic            ny;
    logic            f;
    logic            no;
    logic [15:0]     alu_out;
    logic            alu_zr;
    logic            alu_ng;

    modport master (
        input  inst, inst_vld, in_m, in_m_vld,
        input  alu_out, alu_zr, alu_ng,
        output pc, out_m, write_m, addr_m,
        output alu_x, alu_y, zx, nx, zy, ny, f, no
    );

    modport slave (
        output inst, inst_vld, in_m, in_m_vld,
        output alu_out, alu_zr, alu_ng,
        input  pc, out_m, write_m, addr_m,
        input  alu_x, alu_y, zx, nx, zy, ny, f, no
    );
endinterface

// File: rtl/hack_cpu_ctrl.sv
// Hack CPU sequencer: fetch/exec/wait-for-memory FSM around an external
// combinational ALU, holding the A, D, IR and PC registers.
module hack_cpu_ctrl #(
    parameter int PC_W = 15
) (
    input  logic           clk,
    input  logic           rst,
    hack_cpu_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        WAITM = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [15:0]     a_q;
    logic [15:0]     d_q;
    logic [15:0]     ir_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_inc;
    logic            in_exec;
    logic            m_rdy;
    logic            commit;
    logic            a_exec;
    logic            jmp;

    assign pc_inc  = pc_q + PC_W'(1);
    assign in_exec = (state == EXEC) || (state == WAITM);
    assign m_rdy   = !ir_q[12] || bus.in_m_vld;
    assign commit  = in_exec && ir_q[15] && m_rdy;
    assign a_exec  = (state == EXEC) && !ir_q[15];
    assign jmp     = (ir_q[2] & bus.alu_ng)
                   | (ir_q[1] & bus.alu_zr)
                   | (ir_q[0] & ~bus.alu_ng & ~bus.alu_zr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            FETCH: if (bus.inst_vld) state_nxt = EXEC;
            EXEC: begin
                if (!ir_q[15] || m_rdy) state_nxt = FETCH;
                else state_nxt = WAITM;
            end
            WAITM: if (m_rdy) state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    always_comb begin
        bus.pc      = pc_q;
        bus.addr_m  = a_q[PC_W-1:0];
        bus.alu_x   = d_q;
        bus.alu_y   = ir_q[12] ? bus.in_m : a_q;
        bus.zx      = ir_q[11];
        bus.nx      = ir_q[10];
        bus.zy      = ir_q[9];
        bus.ny      = ir_q[8];
        bus.f       = ir_q[7];
        bus.no      = ir_q[6];
        bus.out_m   = bus.alu_out;
        bus.write_m = commit && ir_q[3];
    end

    // Jump target and addr_m both use the A value from before this commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            d_q  <= '0;
            ir_q <= '0;
            pc_q <= '0;
        end else begin
            unique case (1'b1)
                (state == FETCH) && bus.inst_vld: begin
                    ir_q <= bus.inst;
                end
                a_exec: begin
                    a_q  <= {1'b0, ir_q[14:0]};
                    pc_q <= pc_inc;
                end
                commit: begin
                    if (ir_q[5]) a_q <= bus.alu_out;
                    if (ir_q[4]) d_q <= bus.alu_out;
                    pc_q <= jmp ? a_q[PC_W-1:0] : pc_inc;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Randomised bench for hack_cpu_ctrl with an instruction-level Hack model
// and a per-cycle compare process.
module tb_hack_cpu_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    hack_cpu_ctrl_if #(.PC_W(15)) bus();

    hack_cpu_ctrl #(.PC_W(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] hack_alu(input logic [15:0] x,
                                             input logic [15:0] y,
                                             input logic [5:0]  c);
        logic [15:0] xa, ya, o;
        xa = c[5] ? 16'h0 : x;
        xa = c[4] ? ~xa : xa;
        ya = c[3] ? 16'h0 : y;
        ya = c[2] ? ~ya : ya;
        o  = c[1] ? xa + ya : xa & ya;
        return c[0] ? ~o : o;
    endfunction

    always_comb begin
        bus.alu_out = hack_alu(bus.alu_x, bus.alu_y,
                               {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no});
        bus.alu_zr  = (bus.alu_out == 16'h0);
        bus.alu_ng  = bus.alu_out[15];
    end

    // Architectural model and per-cycle expectations
    logic [15:0] m_a = '0;
    logic [15:0] m_d = '0;
    logic [14:0] m_pc = '0;
    logic        e_wr = 1'b0;
    logic [15:0] e_out = '0;
    logic        e_yv = 1'b0;
    logic [15:0] e_y = '0;
    logic [5:0]  e_ctl = '0;

    int          wr_cnt = 0;
    logic [14:0] wr_addr = '0;
    logic [15:0] wr_out = '0;
    logic [15:0] wr_y = '0;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("pc", 32'(bus.pc), 32'(m_pc));
        chk("d", 32'(bus.alu_x), 32'(m_d));
        chk("addr_m", 32'(bus.addr_m), 32'(m_a[14:0]));
        chk("write_m", 32'(bus.write_m), 32'(e_wr));
        if (e_wr) chk("out_m", 32'(bus.out_m), 32'(e_out));
        if (e_yv) begin
            chk("alu_y", 32'(bus.alu_y), 32'(e_y));
            chk("ctl", 32'({bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no}),
                32'(e_ctl));
        end
        if (bus.write_m) begin
            wr_cnt++;
            wr_addr = bus.addr_m;
            wr_out  = bus.out_m;
            wr_y    = bus.alu_y;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [15:0] i, input int fdly, input int stl,
                       input logic [15:0] mv);
        logic [15:0] y, r;
        logic        lt, eq, gt, j;
        for (int k = 0; k < fdly; k++) begin
            bus.inst_vld = 1'b0;
            bus.inst     = 16'($urandom);
            bus.in_m_vld = 1'($urandom);
            bus.in_m     = 16'($urandom);
            step();
        end
        bus.inst_vld = 1'b1;
        bus.inst     = i;
        bus.in_m_vld = 1'($urandom);
        bus.in_m     = 16'($urandom);
        step();
        bus.inst_vld = 1'b0;
        bus.inst     = 16'($urandom);
        if (!i[15]) begin
            bus.in_m_vld = 1'($urandom);
            step();
            m_a  = {1'b0, i[14:0]};
            m_pc = m_pc + 15'd1;
            return;
        end
        e_ctl = i[11:6];
        if (i[12]) begin
            for (int k = 0; k < stl; k++) begin
                bus.in_m_vld = 1'b0;
                bus.in_m     = 16'($urandom);
                e_yv = 1'b1;
                e_y  = bus.in_m;
                step();
            end
        end
        bus.in_m_vld = i[12] ? 1'b1 : 1'($urandom);
        bus.in_m     = mv;
        y     = i[12] ? mv : m_a;
        r     = hack_alu(m_d, y, i[11:6]);
        e_yv  = 1'b1;
        e_y   = y;
        e_wr  = i[3];
        e_out = r;
        step();
        e_wr = 1'b0;
        e_yv = 1'b0;
        lt = $signed(r) < 0;
        eq = (r == 16'h0);
        gt = !lt && !eq;
        j  = (i[2] && lt) || (i[1] && eq) || (i[0] && gt);
        m_pc = j ? m_a[14:0] : m_pc + 15'd1;
        if (i[5]) m_a = r;
        if (i[4]) m_d = r;
    endtask

    initial begin
        int          wc;
        logic [14:0] p;
        bus.inst     = '0;
        bus.inst_vld = 1'b0;
        bus.in_m     = '0;
        bus.in_m_vld = 1'b0;
        step();
        step();
        chk("rst_pc", 32'(bus.pc), 32'h0);
        chk("rst_wr", 32'(bus.write_m), 32'h0);
        rst = 1'b0;

        // Reset in the middle of an M=D execute cycle
        run(16'h1234, 0, 0, 16'h0);
        run(16'hEC10, 0, 0, 16'h0);
        bus.inst_vld = 1'b1;
        bus.inst     = 16'hE308;
        step();
        bus.inst_vld = 1'b0;
        #1;
        rst  = 1'b1;
        m_a  = '0;
        m_d  = '0;
        m_pc = '0;
        #1;
        chk("mid_rst_pc", 32'(bus.pc), 32'h0);
        chk("mid_rst_a", 32'(bus.addr_m), 32'h0);
        chk("mid_rst_d", 32'(bus.alu_x), 32'h0);
        chk("mid_rst_wr", 32'(bus.write_m), 32'h0);
        step();
        rst = 1'b0;
        run(16'h0005, 0, 0, 16'h0);
        chk("a5", 32'(bus.addr_m), 32'h5);
        chk("pc1", 32'(bus.pc), 32'h1);

        // D+M into D,M with a stalled read
        run(16'h0003, 0, 0, 16'h0);
        run(16'hEC10, 0, 0, 16'h0);
        run(16'h0007, 0, 0, 16'h0);
        wc = wr_cnt;
        p  = bus.pc;
        run(16'hF098, 0, 3, 16'd10);
        chk("dm_wrs", 32'(wr_cnt - wc), 32'd1);
        chk("dm_addr", 32'(wr_addr), 32'd7);
        chk("dm_out", 32'(wr_out), 32'd13);
        chk("dm_y", 32'(wr_y), 32'd10);
        chk("dm_d", 32'(bus.alu_x), 32'd13);
        chk("dm_pc", 32'(bus.pc), 32'(p + 15'd1));

        // Jumps
        run(16'hEE90, 0, 0, 16'h0);
        run(16'h0064, 0, 0, 16'h0);
        run(16'hE304, 0, 0, 16'h0);
        chk("jlt_t", 32'(bus.pc), 32'd100);
        run(16'hEA90, 0, 0, 16'h0);
        run(16'h0064, 0, 0, 16'h0);
        p = bus.pc;
        run(16'hE304, 0, 0, 16'h0);
        chk("jlt_nt", 32'(bus.pc), 32'(p + 15'd1));
        run(16'hE302, 0, 0, 16'h0);
        chk("jeq_t", 32'(bus.pc), 32'd100);

        // AM=A+1 writes to the old A
        run(16'h0014, 0, 0, 16'h0);
        run(16'hEDE8, 0, 0, 16'h0);
        chk("am_addr", 32'(wr_addr), 32'd20);
        chk("am_out", 32'(wr_out), 32'd21);
        chk("am_a", 32'(bus.addr_m), 32'd21);

        // Fetch wait, then PC wrap
        run(16'h0001, 5, 0, 16'h0);
        run(16'h7FFF, 0, 0, 16'h0);
        run(16'hEA87, 0, 0, 16'h0);
        chk("pc_top", 32'(bus.pc), 32'h7FFF);
        run(16'h0001, 0, 0, 16'h0);
        chk("pc_wrap", 32'(bus.pc), 32'h0);
        run(16'hFFFF, 0, 2, 16'h1234);

        for (int n = 0; n < 300; n++) begin
            run(16'($urandom), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), 16'($urandom));
        end
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
